// File: rtl/cgra_config_sequencer.sv
// cgra_config_sequencer: streams (addr, data) bitstream words onto the CGRA
// config bus while the array is stalled, then clears flush, unstalls, and
// pulses flush to launch the application.
// Optional build macro CFG_SEQ_VERIFY_EN: adds per-word readback verification
// (RD_CHK state, sticky error/err_addr). Undefined: error/err_addr tied to 0.
module cgra_config_sequencer #(
  parameter int unsigned NUM_STALL = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned FLUSH_CYC = 2,
  parameter logic [31:0] FLUSH_ON  = 32'h001C_7E00,
  parameter logic [31:0] FLUSH_OFF = 32'h001C_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          flush_xy,
  input  logic                 bs_valid,
  output logic                 bs_ready,
  input  logic [31:0]          bs_addr,
  input  logic [31:0]          bs_data,
  input  logic                 bs_last,
  output logic [31:0]          cfg_addr,
  output logic [31:0]          cfg_data,
  output logic                 cfg_write,
  output logic                 cfg_read,
  input  logic [31:0]          read_config_data,
  output logic [NUM_STALL-1:0] stall,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          err_addr
);

  localparam int unsigned CNT_MAX = (RD_LAT > FLUSH_CYC) ? RD_LAT : FLUSH_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] FL_LAST = CW'(FLUSH_CYC - 1);
`ifdef CFG_SEQ_VERIFY_EN
  localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_STALL, S_WR_ACC, S_WR_PULSE,
`ifdef CFG_SEQ_VERIFY_EN
    S_RD_CHK,
`endif
    S_FL_CLR, S_UNSTALL, S_FL_ON, S_FL_OFF, S_DONE
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [31:0]            r_addr, w_addr_nxt;
  logic [31:0]            r_data, w_data_nxt;
  logic                   r_last, w_last_nxt;
  logic [31:0]            r_cfg_addr, w_cfg_addr_nxt;
  logic [31:0]            r_cfg_data, w_cfg_data_nxt;
  logic                   r_cfg_write, w_cfg_write_nxt;
  logic                   r_cfg_read, w_cfg_read_nxt;
  logic                   r_bs_ready, w_bs_ready_nxt;
  logic [NUM_STALL-1:0]   r_stall, w_stall_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
`ifdef CFG_SEQ_VERIFY_EN
  logic                   r_error, w_error_nxt;
  logic [31:0]            r_err_addr, w_err_addr_nxt;
`else
  logic                   w_unused_rd;
  assign w_unused_rd = ^read_config_data;
`endif

  // Reset synchronizer: asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Next state and next registered outputs; outputs are decoded for the state being entered
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_last_nxt      = r_last;
    w_cfg_addr_nxt  = r_cfg_addr;
    w_cfg_data_nxt  = r_cfg_data;
    w_cfg_write_nxt = 1'b0;
    w_cfg_read_nxt  = 1'b0;
    w_bs_ready_nxt  = 1'b0;
    w_stall_nxt     = r_stall;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
`ifdef CFG_SEQ_VERIFY_EN
    w_error_nxt     = r_error;
    w_err_addr_nxt  = r_err_addr;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_STALL;
          w_stall_nxt = '1;
          w_busy_nxt  = 1'b1;
`ifdef CFG_SEQ_VERIFY_EN
          w_error_nxt    = 1'b0;
          w_err_addr_nxt = '0;
`endif
        end
      end
      S_STALL: begin
        w_state_nxt    = S_WR_ACC;
        w_bs_ready_nxt = 1'b1;
      end
      S_WR_ACC: begin
        if (bs_valid) begin
          w_state_nxt     = S_WR_PULSE;
          w_addr_nxt      = bs_addr;
          w_data_nxt      = bs_data;
          w_last_nxt      = bs_last;
          w_cfg_addr_nxt  = bs_addr;
          w_cfg_data_nxt  = bs_data;
          w_cfg_write_nxt = 1'b1;
        end else begin
          w_bs_ready_nxt = 1'b1;
        end
      end
      S_WR_PULSE: begin
`ifdef CFG_SEQ_VERIFY_EN
        w_state_nxt    = S_RD_CHK;
        w_cfg_read_nxt = 1'b1;
        w_cnt_nxt      = '0;
`else
        if (r_last) begin
          w_state_nxt     = S_FL_CLR;
          w_cfg_write_nxt = 1'b1;
          w_cfg_addr_nxt  = {16'h0, flush_xy};
          w_cfg_data_nxt  = FLUSH_OFF;
        end else begin
          w_state_nxt    = S_WR_ACC;
          w_bs_ready_nxt = 1'b1;
        end
`endif
      end
`ifdef CFG_SEQ_VERIFY_EN
      S_RD_CHK: begin
        if (r_cnt == RD_LAST) begin
          if (read_config_data != r_data) begin
            // Abort with the array still stalled; no flush is issued
            w_state_nxt    = S_DONE;
            w_done_nxt     = 1'b1;
            w_error_nxt    = 1'b1;
            w_err_addr_nxt = r_addr;
          end else if (r_last) begin
            w_state_nxt     = S_FL_CLR;
            w_cfg_write_nxt = 1'b1;
            w_cfg_addr_nxt  = {16'h0, flush_xy};
            w_cfg_data_nxt  = FLUSH_OFF;
          end else begin
            w_state_nxt    = S_WR_ACC;
            w_bs_ready_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt      = r_cnt + CW'(1);
          w_cfg_read_nxt = 1'b1;
        end
      end
`endif
      S_FL_CLR: begin
        w_state_nxt = S_UNSTALL;
        w_stall_nxt = '0;
      end
      S_UNSTALL: begin
        w_state_nxt     = S_FL_ON;
        w_cfg_write_nxt = 1'b1;
        w_cfg_data_nxt  = FLUSH_ON;
        w_cnt_nxt       = '0;
      end
      S_FL_ON: begin
        w_cfg_write_nxt = 1'b1;
        if (r_cnt == FL_LAST) begin
          w_state_nxt    = S_FL_OFF;
          w_cfg_data_nxt = FLUSH_OFF;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_FL_OFF: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_cfg_write <= 1'b0;
      r_cfg_read  <= 1'b0;
      r_bs_ready  <= 1'b0;
      r_stall     <= '1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef CFG_SEQ_VERIFY_EN
      r_error     <= 1'b0;
      r_err_addr  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_last      <= w_last_nxt;
      r_cfg_addr  <= w_cfg_addr_nxt;
      r_cfg_data  <= w_cfg_data_nxt;
      r_cfg_write <= w_cfg_write_nxt;
      r_cfg_read  <= w_cfg_read_nxt;
      r_bs_ready  <= w_bs_ready_nxt;
      r_stall     <= w_stall_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
`ifdef CFG_SEQ_VERIFY_EN
      r_error     <= w_error_nxt;
      r_err_addr  <= w_err_addr_nxt;
`endif
    end
  end

  assign bs_ready  = r_bs_ready;
  assign cfg_addr  = r_cfg_addr;
  assign cfg_data  = r_cfg_data;
  assign cfg_write = r_cfg_write;
  assign cfg_read  = r_cfg_read;
  assign stall     = r_stall;
  assign busy      = r_busy;
  assign done      = r_done;
`ifdef CFG_SEQ_VERIFY_EN
  assign error     = r_error;
  assign err_addr  = r_err_addr;
`else
  assign error     = 1'b0;
  assign err_addr  = '0;
`endif

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Directed testbench for cgra_config_sequencer, including a behavioural
// config memory that answers readback strobes.
module tb_cgra_config_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] flush_xy;
  logic        bs_valid;
  logic        bs_ready;
  logic [31:0] bs_addr;
  logic [31:0] bs_data;
  logic        bs_last;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_write;
  logic        cfg_read;
  logic [31:0] read_config_data;
  logic [3:0]  stall;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  // Monitor log
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [3:0]  wr_stall [64];
  int          wr_n = 0;
  int          done_n = 0;
  int          overlap_n = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] bad_addr = 32'hFFFF_FFFF;

  logic [31:0] wa [3];
  logic [31:0] wd [3];

  always #5 clk = ~clk;

  cgra_config_sequencer #(
    .NUM_STALL(4), .RD_LAT(1), .FLUSH_CYC(2),
    .FLUSH_ON(32'h001C_7E00), .FLUSH_OFF(32'h001C_0000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush_xy(flush_xy),
    .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_addr(bs_addr),
    .bs_data(bs_data), .bs_last(bs_last), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_write(cfg_write), .cfg_read(cfg_read),
    .read_config_data(read_config_data), .stall(stall), .busy(busy),
    .done(done), .error(error), .err_addr(err_addr)
  );

  // Bus monitor and config memory model; runs on the falling edge
  always @(negedge clk) begin
    if (cfg_write) begin
      if (wr_n < 64) begin
        wr_addr[wr_n]  = cfg_addr;
        wr_data[wr_n]  = cfg_data;
        wr_stall[wr_n] = stall;
      end
      wr_n++;
      mem[cfg_addr] = cfg_data;
    end
    if (cfg_read) begin
      if (cfg_addr == bad_addr) read_config_data = 32'hB;
      else if (mem.exists(cfg_addr)) read_config_data = mem[cfg_addr];
      else read_config_data = '0;
    end
    if (cfg_write && cfg_read) overlap_n++;
    if (done) done_n++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d,
                           input logic l, input int gap);
    int  w0;
    bit  ok;
    w0 = 0;
    bs_valid = 1'b0;
    for (int g = 1; g <= gap; g++) begin
      tick;
      if (g == 3) w0 = wr_n;
    end
    if (gap >= 4) begin
      checks++;
      if (wr_n !== w0 || bs_ready !== 1'b1) begin
        errors++;
        $display("FAIL gap_idle: writes=%0d ready=%b, required writes=%0d ready=1", wr_n, bs_ready, w0);
      end
    end
    bs_addr = a; bs_data = d; bs_last = l; bs_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bs_ready) begin
        tick;
        ok = 1'b1;
        break;
      end
      tick;
    end
    bs_valid = 1'b0;
    bs_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: addr=%h not accepted, required acceptance", a);
    end
  endtask

  task automatic wait_done(input bit start_on_done);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        if (start_on_done) start = 1'b1;
        tick;
        start = 1'b0;
        ok = 1'b1;
        break;
      end
      tick;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done pulse, required one");
    end
  endtask

  task automatic run_seq(input int gap, input bit busy_start, input bit done_start);
    wr_n = 0;
    pulse_start;
    for (int i = 0; i < 3; i++) begin
      send_word(wa[i], wd[i], (i == 2), (i == 0) ? 0 : gap);
      if (i == 0 && busy_start) pulse_start;
    end
    wait_done(done_start);
  endtask

  // Expected log of a successful three-word run
  task automatic check_full_log(input string tag);
    logic [31:0] ea [7];
    logic [31:0] ed [7];
    logic [3:0]  es [7];
    for (int i = 0; i < 3; i++) begin
      ea[i] = wa[i]; ed[i] = wd[i]; es[i] = 4'hF;
    end
    ea[3] = 32'h0000_0302; ed[3] = 32'h001C_0000; es[3] = 4'hF;
    ea[4] = 32'h0000_0302; ed[4] = 32'h001C_7E00; es[4] = 4'h0;
    ea[5] = 32'h0000_0302; ed[5] = 32'h001C_7E00; es[5] = 4'h0;
    ea[6] = 32'h0000_0302; ed[6] = 32'h001C_0000; es[6] = 4'h0;
    checks++;
    if (wr_n !== 7) begin
      errors++;
      $display("FAIL %s_write_count: got %0d, required 7", tag, wr_n);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_stall[i] !== es[i]) begin
        errors++;
        $display("FAIL %s_wr%0d: got %h<=%h stall=%h, required %h<=%h stall=%h",
                 tag, i, wr_addr[i], wr_data[i], wr_stall[i], ea[i], ed[i], es[i]);
      end
    end
  endtask

  task automatic check_idle_after(input string tag, input logic [3:0] exp_stall);
    checks++;
    if (busy !== 1'b0 || stall !== exp_stall) begin
      errors++;
      $display("FAIL %s_idle: busy=%b stall=%h, required busy=0 stall=%h", tag, busy, stall, exp_stall);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick;
    checks++;
    if (stall !== 4'hF) begin errors++; $display("FAIL rst_stall: got %h, required f", stall); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_busy_done: got %b%b, required 00", busy, done);
    end
    checks++;
    if (cfg_write !== 1'b0 || cfg_read !== 1'b0 || bs_ready !== 1'b0) begin
      errors++; $display("FAIL rst_strobes: w=%b r=%b rdy=%b, required 0 0 0", cfg_write, cfg_read, bs_ready);
    end
    checks++;
    if (error !== 1'b0 || err_addr !== 32'h0 || cfg_addr !== 32'h0) begin
      errors++; $display("FAIL rst_err: err=%b err_addr=%h cfg_addr=%h, required 0", error, err_addr, cfg_addr);
    end
    reset_n = 1'b1;
    repeat (4) tick;
    check_idle_after("rst_release", 4'hF);
  endtask

  task automatic test_three_words;
    int d0;
    d0 = done_n;
    wr_n = 0;
    pulse_start;
    checks++;
    if (busy !== 1'b1 || stall !== 4'hF) begin
      errors++; $display("FAIL t2_busy: busy=%b stall=%h, required 1 f", busy, stall);
    end
    for (int i = 0; i < 3; i++) send_word(wa[i], wd[i], (i == 2), 0);
    wait_done(1'b0);
    check_full_log("t2");
    checks++;
    if (done_n !== d0 + 1) begin errors++; $display("FAIL t2_done_count: got %0d, required %0d", done_n - d0, 1); end
    check_idle_after("t2", 4'h0);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL t2_error: got %b, required 0", error); end
  endtask

  task automatic test_verify;
    int d0;
    d0 = done_n;
    bad_addr = 32'h0003_0101;
    run_seq(0, 1'b0, 1'b0);
    bad_addr = 32'hFFFF_FFFF;
`ifdef CFG_SEQ_VERIFY_EN
    checks++;
    if (wr_n !== 3) begin errors++; $display("FAIL t3_writes: got %0d, required 3 (no flush)", wr_n); end
    checks++;
    if (error !== 1'b1 || err_addr !== 32'h0003_0101) begin
      errors++; $display("FAIL t3_error: err=%b addr=%h, required 1 00030101", error, err_addr);
    end
    checks++;
    if (done_n !== d0 + 1) begin errors++; $display("FAIL t3_done_count: got %0d, required 1", done_n - d0); end
    repeat (3) tick;
    check_idle_after("t3", 4'hF);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL t3_sticky: got %b, required 1", error); end
    pulse_start;
    checks++;
    if (error !== 1'b0 || err_addr !== 32'h0) begin
      errors++; $display("FAIL t3_clear: err=%b addr=%h, required 0 0", error, err_addr);
    end
    wr_n = 0;
    for (int i = 0; i < 3; i++) send_word(wa[i], wd[i], (i == 2), 0);
    wait_done(1'b0);
    check_full_log("t3_rerun");
`else
    check_full_log("t3_noverify");
    checks++;
    if (error !== 1'b0 || err_addr !== 32'h0 || done_n !== d0 + 1) begin
      errors++; $display("FAIL t3_tied: err=%b addr=%h dones=%0d, required 0 0 1", error, err_addr, done_n - d0);
    end
`endif
  endtask

  task automatic test_gap;
    int d0;
    d0 = done_n;
    run_seq(20, 1'b0, 1'b0);
    check_full_log("t4");
    checks++;
    if (done_n !== d0 + 1) begin errors++; $display("FAIL t4_done_count: got %0d, required 1", done_n - d0); end
  endtask

  task automatic test_reset_mid;
    pulse_start;
    send_word(wa[0], wd[0], 1'b0, 0);
    bs_addr = wa[1]; bs_data = wd[1]; bs_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    bs_valid = 1'b0;
    checks++;
    if (stall !== 4'hF || busy !== 1'b0 || cfg_write !== 1'b0 || cfg_read !== 1'b0 || bs_ready !== 1'b0) begin
      errors++;
      $display("FAIL t5_abort: stall=%h busy=%b w=%b r=%b rdy=%b, required f 0 0 0 0",
               stall, busy, cfg_write, cfg_read, bs_ready);
    end
    repeat (2) tick;
    reset_n = 1'b1;
    repeat (4) tick;
    check_idle_after("t5_reset", 4'hF);
    run_seq(0, 1'b0, 1'b0);
    check_full_log("t5_rerun");
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_n;
    run_seq(0, 1'b1, 1'b1);
    repeat (6) tick;
    check_full_log("t6");
    checks++;
    if (done_n !== d0 + 1) begin errors++; $display("FAIL t6_done_count: got %0d, required 1", done_n - d0); end
    check_idle_after("t6", 4'h0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; flush_xy = 16'h0302;
    bs_valid = 1'b0; bs_addr = '0; bs_data = '0; bs_last = 1'b0;
    read_config_data = '0;
    wa[0] = 32'h0001_0101; wd[0] = 32'hA;
    wa[1] = 32'h0002_0101; wd[1] = 32'hB;
    wa[2] = 32'h0003_0101; wd[2] = 32'hC;
    test_reset;
    test_three_words;
    test_verify;
    test_gap;
    test_reset_mid;
    test_back_to_back;
    checks++;
    if (overlap_n !== 0) begin
      errors++; $display("FAIL rw_overlap: %0d cycles with read and write, required 0", overlap_n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
